// File: rtl/add_rr_scheduler_if.sv
// Per-channel FIFO handshake bundle for the shared-adder scheduler.
// The scheduler is the master: it pops input FIFOs and pushes output FIFOs.
interface add_rr_scheduler_if #(
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0]    inA_rd_en;
  logic [NUM_CH-1:0]    inA_empty;
  logic [32*NUM_CH-1:0] inA_dout;
  logic [NUM_CH-1:0]    inB_rd_en;
  logic [NUM_CH-1:0]    inB_empty;
  logic [32*NUM_CH-1:0] inB_dout;
  logic [NUM_CH-1:0]    out_wr_en;
  logic [NUM_CH-1:0]    out_full;
  logic [31:0]          out_din;

  modport master (
    output inA_rd_en, inB_rd_en, out_wr_en, out_din,
    input  inA_empty, inA_dout, inB_empty, inB_dout, out_full
  );

  modport slave (
    input  inA_rd_en, inB_rd_en, out_wr_en, out_din,
    output inA_empty, inA_dout, inB_empty, inB_dout, out_full
  );
endinterface

// File: rtl/add_rr_scheduler.sv
// One signed 32-bit adder time-shared round-robin between NUM_CH channels,
// each with A/B show-ahead input FIFOs and an output FIFO.
module add_rr_scheduler #(
  parameter int  NUM_CH   = 2,
  parameter bit  SATURATE = 1'b0,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  add_rr_scheduler_if.master bus,
  output logic [CH_W-1:0]   grant_ch,
  output logic              busy
);

  typedef enum logic {S_ARB, S_WR} state_t;

  state_t             state;
  logic [31:0]        sum;
  logic [CH_W-1:0]    ch;
  logic [CH_W-1:0]    last;

  logic [NUM_CH-1:0]  elig;
  logic               found;
  logic [CH_W-1:0]    g;
  logic signed [31:0] a_sel;
  logic signed [31:0] b_sel;
  logic signed [32:0] wide;
  logic [31:0]        sum_c;

  assign elig = ~bus.inA_empty & ~bus.inB_empty & ~bus.out_full;

  // Search starts just past the last channel written, so priority rotates.
  always_comb begin : arbitrate
    int idx;
    found = 1'b0;
    g     = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(last) + k) % NUM_CH;
      if (!found && elig[idx]) begin
        found = 1'b1;
        g     = CH_W'(idx);
      end
    end
  end

  always_comb begin : adder
    a_sel = bus.inA_dout[32*g +: 32];
    b_sel = bus.inB_dout[32*g +: 32];
    wide  = {a_sel[31], a_sel} + {b_sel[31], b_sel};
    if (SATURATE && (wide[32] != wide[31]))
      sum_c = wide[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else
      sum_c = wide[31:0];
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin : drive_outputs
    bus.inA_rd_en = '0;
    bus.inB_rd_en = '0;
    bus.out_wr_en = '0;
    bus.out_din   = '0;
    if (!reset) begin
      case (state)
        S_ARB: begin
          if (found) begin
            bus.inA_rd_en[g] = 1'b1;
            bus.inB_rd_en[g] = 1'b1;
          end
        end
        S_WR: begin
          if (!bus.out_full[ch]) begin
            bus.out_wr_en[ch] = 1'b1;
            bus.out_din       = sum;
          end
        end
        default: ;
      endcase
    end
  end

  assign grant_ch = reset ? '0 : ch;
  assign busy     = !reset && (state == S_WR);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_ARB;
      sum   <= '0;
      ch    <= '0;
      last  <= CH_W'(NUM_CH - 1);
    end else begin
      case (state)
        S_ARB: begin
          if (found) begin
            sum   <= sum_c;
            ch    <= g;
            state <= S_WR;
          end
        end
        S_WR: begin
          // A full output FIFO stalls here; the held sum is never dropped.
          if (!bus.out_full[ch]) begin
            last  <= ch;
            state <= S_ARB;
          end
        end
        default: state <= S_ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_add_rr_scheduler.sv
// Directed bench: two 2-channel instances (wrap / saturate) share a vector
// table; a 3-channel instance covers pointer wrap and reset during a write.
module tb_add_rr_scheduler;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int pass_cnt  = 0;
  int check_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Shared stimulus for the two 2-channel instances.
  logic [1:0]  a_empty, b_empty, o_full;
  logic [31:0] a0, b0, a1, b1;

  add_rr_scheduler_if #(.NUM_CH(2)) bus_w ();
  add_rr_scheduler_if #(.NUM_CH(2)) bus_s ();
  add_rr_scheduler_if #(.NUM_CH(3)) bus_3 ();

  assign bus_w.inA_empty = a_empty;
  assign bus_w.inB_empty = b_empty;
  assign bus_w.out_full  = o_full;
  assign bus_w.inA_dout  = {a1, a0};
  assign bus_w.inB_dout  = {b1, b0};
  assign bus_s.inA_empty = a_empty;
  assign bus_s.inB_empty = b_empty;
  assign bus_s.out_full  = o_full;
  assign bus_s.inA_dout  = {a1, a0};
  assign bus_s.inB_dout  = {b1, b0};

  logic [2:0] e3, f3;
  assign bus_3.inA_empty = e3;
  assign bus_3.inB_empty = e3;
  assign bus_3.out_full  = f3;
  assign bus_3.inA_dout  = {32'd20, 32'd10, 32'd0};
  assign bus_3.inB_dout  = {32'd1, 32'd1, 32'd1};

  logic       grant_w, grant_s, busy_w, busy_s, busy_3;
  logic [1:0] grant_3;

  add_rr_scheduler #(.NUM_CH(2), .SATURATE(1'b0)) dut_w (
    .clock(clock), .reset(reset), .bus(bus_w), .grant_ch(grant_w), .busy(busy_w));
  add_rr_scheduler #(.NUM_CH(2), .SATURATE(1'b1)) dut_s (
    .clock(clock), .reset(reset), .bus(bus_s), .grant_ch(grant_s), .busy(busy_s));
  add_rr_scheduler #(.NUM_CH(3), .SATURATE(1'b0)) dut_3 (
    .clock(clock), .reset(reset), .bus(bus_3), .grant_ch(grant_3), .busy(busy_3));

  typedef struct {
    logic [1:0]  ae, be, of;
    logic [31:0] a0, b0, a1, b1;
    logic [1:0]  rd, wr;
    logic [31:0] din, din_sat;
    logic        grant, busy;
  } vec_t;

  vec_t vecs[16];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int i0, i1, k0, k1, nw, w0, w1, exp_ch;
    int order[$];
    logic pop_a0, pop_b1;

    // ae, be, of, a0, b0, a1, b1, rd, wr, din, din_sat, grant, busy
    vecs[0]  = '{2'b01, 2'b01, 2'b00, 0, 0, 5, 32'hFFFF_FFF9, 2'b10, 2'b00, 0, 0, 0, 0};
    vecs[1]  = '{2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b10, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1, 1};
    vecs[2]  = '{2'b10, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0};
    vecs[3]  = '{2'b11, 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0};
    vecs[4]  = '{2'b00, 2'b00, 2'b01, 0, 0, 10, 20, 2'b10, 2'b00, 0, 0, 1, 0};
    vecs[5]  = '{2'b00, 2'b00, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1};
    vecs[6]  = '{2'b00, 2'b00, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1};
    vecs[7]  = '{2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b10, 30, 30, 1, 1};
    vecs[8]  = '{2'b00, 2'b00, 2'b00, 3, 4, 9, 9, 2'b01, 2'b00, 0, 0, 1, 0};
    vecs[9]  = '{2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 7, 7, 0, 1};
    vecs[10] = '{2'b00, 2'b00, 2'b00, 0, 0, 32'hFFFF_FF9C, 50, 2'b10, 2'b00, 0, 0, 0, 0};
    vecs[11] = '{2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b10, 32'hFFFF_FFCE, 32'hFFFF_FFCE, 1, 1};
    vecs[12] = '{2'b00, 2'b00, 2'b00, 32'h7FFF_FFF0, 32'h20, 0, 0, 2'b01, 2'b00, 0, 0, 1, 0};
    vecs[13] = '{2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 32'h8000_0010, 32'h7FFF_FFFF, 0, 1};
    vecs[14] = '{2'b00, 2'b00, 2'b00, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 2'b00, 0, 0, 0, 0};
    vecs[15] = '{2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b10, 32'h7FFF_FFFF, 32'h8000_0000, 1, 1};

    // Reset state with every channel ready: nothing may be popped.
    a_empty = 2'b00; b_empty = 2'b00; o_full = 2'b00;
    a0 = 1; b0 = 2; a1 = 3; b1 = 4;
    e3 = 3'b000; f3 = 3'b000;
    #2;
    check("reset_ctl_w", {bus_w.inA_rd_en, bus_w.inB_rd_en, bus_w.out_wr_en, grant_w, busy_w}, 0);
    check("reset_din_w", bus_w.out_din, 0);
    check("reset_ctl_s", {bus_s.inA_rd_en, bus_s.inB_rd_en, bus_s.out_wr_en, grant_s, busy_s}, 0);
    @(negedge clock);
    reset = 1'b0;

    // Table: single-channel grants, partial readiness, full-masking, S_WR hold, overflow.
    for (int i = 0; i < 16; i++) begin
      a_empty = vecs[i].ae; b_empty = vecs[i].be; o_full = vecs[i].of;
      a0 = vecs[i].a0; b0 = vecs[i].b0; a1 = vecs[i].a1; b1 = vecs[i].b1;
      #1;
      check($sformatf("vec%0d_ctl_w", i),
            {bus_w.inA_rd_en, bus_w.inB_rd_en, bus_w.out_wr_en, grant_w, busy_w},
            {vecs[i].rd, vecs[i].rd, vecs[i].wr, vecs[i].grant, vecs[i].busy});
      check($sformatf("vec%0d_din_w", i), bus_w.out_din, vecs[i].din);
      check($sformatf("vec%0d_ctl_s", i),
            {bus_s.inA_rd_en, bus_s.inB_rd_en, bus_s.out_wr_en, grant_s, busy_s},
            {vecs[i].rd, vecs[i].rd, vecs[i].wr, vecs[i].grant, vecs[i].busy});
      check($sformatf("vec%0d_din_s", i), bus_s.out_din, vecs[i].din_sat);
      tick();
    end

    // Both channels continuously ready: alternate ch0/ch1, one write every 2 cycles.
    reset = 1'b1; #1; reset = 1'b0;
    i0 = 0; i1 = 0; k0 = 0; k1 = 0; nw = 0; exp_ch = 0;
    a_empty = 2'b00; b_empty = 2'b00; o_full = 2'b00;
    for (int c = 0; c < 16; c++) begin
      a0 = 32'(i0); b0 = 1; a1 = 100; b1 = 32'(i1);
      #1;
      if (bus_w.out_wr_en != 2'b00) begin
        check("t2_ch", bus_w.out_wr_en, (exp_ch == 1) ? 2'b10 : 2'b01);
        check("t2_val", bus_w.out_din, (exp_ch == 1) ? 32'(100 + k1) : 32'(k0 + 1));
        check("t2_cycle", c % 2, 1);
        if (exp_ch == 1) k1++; else k0++;
        exp_ch = 1 - exp_ch;
        nw++;
      end
      pop_a0 = bus_w.inA_rd_en[0];
      pop_b1 = bus_w.inB_rd_en[1];
      tick();
      if (pop_a0) i0++;
      if (pop_b1) i1++;
    end
    check("t2_writes", nw, 8);

    // ch0 output full for 10 cycles: only ch1 served, ch0 first once released.
    reset = 1'b1; #1; reset = 1'b0;
    w0 = 0; w1 = 0;
    o_full = 2'b01;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus_w.out_wr_en[0]) w0++;
      if (bus_w.out_wr_en[1]) w1++;
      tick();
    end
    check("t3_ch0_writes", w0, 0);
    check("t3_ch1_writes", w1, 5);
    o_full = 2'b00;
    #1;
    check("t3_resume_pop", {bus_w.inA_rd_en, bus_w.inB_rd_en}, 4'b0101);
    tick();

    // Three channels: grant order 0,1,2,0 then reset while holding a sum.
    reset = 1'b1; #1; reset = 1'b0;
    e3 = 3'b000; f3 = 3'b000;
    for (int c = 0; c < 8; c++) begin
      #1;
      for (int ch = 0; ch < 3; ch++) begin
        if (bus_3.out_wr_en[ch]) begin
          order.push_back(ch);
          check("t6_val", bus_3.out_din, 32'(10 * ch + 1));
        end
      end
      tick();
    end
    check("t6_nwrites", order.size(), 4);
    if (order.size() == 4) begin
      check("t6_order", {8'(order[0]), 8'(order[1]), 8'(order[2]), 8'(order[3])},
            {8'd0, 8'd1, 8'd2, 8'd0});
    end
    #1;
    check("t6_pop_ch1", bus_3.inA_rd_en, 3'b010);
    tick();
    check("t6_in_wr", {grant_3, busy_3}, 3'b011);
    reset = 1'b1;
    #1;
    check("t6_reset_ctl", {bus_3.inA_rd_en, bus_3.inB_rd_en, bus_3.out_wr_en, grant_3, busy_3}, 0);
    check("t6_reset_din", bus_3.out_din, 0);
    reset = 1'b0;
    #1;
    check("t6_first_after_reset", {bus_3.inA_rd_en, bus_3.inB_rd_en}, 6'b001_001);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
